ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends one command byte from the FPGA to the keyboard, for example 0xED (set LEDs) followed by the LED mask byte. The block runs on FPGAClk. It drives the open-drain PS/2 clock and data lines through active-low output enables and paces the bits from the synchronised device clock. It sits beside the keyboard receiver path, and it keeps clock and data released whenever it is idle.

Parameters:
INHIBIT_CYCLES, 5000, FPGAClk cycles the clock line is held low before the start bit (100 us at 50 MHz).
TIMEOUT_CYCLES, 1000000, watchdog limit in FPGAClk cycles (20 ms at 50 MHz); used only when the optional feature is compiled in.

Ports:
FPGAClk  in  1  system clock; the only clock in the block.
rst  in  1  asynchronous, active-high reset.
tx_data  in  8  command byte; sampled when tx_valid && tx_ready.
tx_valid  in  1  request to send.
tx_ready  out  1  high only in IDLE.
ps2_clk_in  in  1  raw PS/2 clock pin, asynchronous.
ps2_data_in  in  1  raw PS/2 data pin, asynchronous.
ps2_clk_oe  out  1  1 = pull the PS/2 clock low.
ps2_data_oe  out  1  1 = pull the PS/2 data low.
tx_busy  out  1  high in any state other than IDLE.
tx_done  out  1  one-cycle pulse: byte sent and device ACK seen.
tx_err  out  1  one-cycle pulse: ACK missing, or timeout.

Behaviour:
- Reset values: state IDLE; tx_ready=1; ps2_clk_oe=0; ps2_data_oe=0; tx_busy=0; tx_done=0; tx_err=0; bit count 0; synchronisers all 1.
- ps2_clk_in and ps2_data_in each pass through a 2-flop synchroniser. A falling edge (fall) is a 1-cycle strobe: previous synced clock = 1 and current synced clock = 0.
- Handshake: tx_valid && tx_ready in IDLE latches tx_data and computes the odd parity bit (~^tx_data). The next state is INHIBIT. tx_valid is ignored outside IDLE.
- INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles. On the last of those cycles, ps2_data_oe is set to 1 (start bit = 0). Next state is RELEASE.
- RELEASE: ps2_clk_oe=0 and ps2_data_oe stays 1. Go to SHIFT on the next cycle with bit count = 0.
- SHIFT: on each fall, the host drives the next bit and increments the bit count. Driving bit b means ps2_data_oe = ~b.
  - Falls 1..8: data bits d0..d7, LSB first.
  - Fall 9: the parity bit.
  - Fall 10: stop bit; ps2_data_oe=0 (line released).
  - Outputs hold between falls.
- ACK: on fall 11, sample the synced data line.
  - 0: go to WAIT_IDLE.
  - 1: pulse tx_err, then go to WAIT_IDLE.
- WAIT_IDLE: wait until the synced clock and data are both 1. Then pulse tx_done (only if no error was flagged), and go to IDLE.
- tx_done and tx_err are never asserted in the same cycle. A byte produces exactly one of them.
- Reset mid-operation: both output enables release immediately (asynchronously) and the byte is dropped. No done or err pulse is issued.
- Falls seen in IDLE, INHIBIT or RELEASE are ignored; receiver-direction traffic does not advance the block.
- Bit count is 4 bits. It saturates at 11 and never wraps.

Optional Feature:
PS2_TX_TIMEOUT_EN
- Defined: a watchdog counter resets on entry to RELEASE and on every fall. If it reaches TIMEOUT_CYCLES in SHIFT, ACK or WAIT_IDLE, the block:
  - releases both lines,
  - pulses tx_err,
  - returns to IDLE.
- Not defined: no watchdog logic is built, and the block waits indefinitely for device clocks.

Test Plan:
1. Reset, then tx_data=0xED with tx_valid=1, and a device model that clocks 11 falls and pulls data low at fall 11. Required: clk_oe high for exactly 5000 cycles; line bits 0,1,0,1,1,0,1,1,1,1 (start, d0..d7, parity=1); tx_done pulses once; tx_err stays 0.
2. tx_data=0x01, with the device releasing data at fall 11 (no ACK). Required: parity bit 0 on the line; tx_err pulses once; no tx_done; tx_ready returns to 1.
3. tx_data=0x00 followed immediately by 0xFF, with tx_valid held high. Required: the second byte is accepted only after tx_ready reasserts; parity is 1 for both bytes.
4. Assert rst after fall 5 of a transfer. Required: ps2_clk_oe=0 and ps2_data_oe=0 in the same cycle; tx_ready=1 after reset; no done or err pulse.
5. Toggle ps2_clk_in while in IDLE. Required: no state change, and both output enables stay 0.
6. With PS2_TX_TIMEOUT_EN defined, stop device clocks after fall 4. Required: tx_err pulses 1000000 cycles after the last fall; lines are released; the block returns to IDLE.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte (start, d0..d7, odd
// parity, stop) to the device, paced by the synchronised device clock, then
// checks the device ACK. Both lines are open-drain and driven through
// active-low output enables.
// Optional build macro: PS2_TX_TIMEOUT_EN adds a watchdog that abandons the
// transfer when the device stops clocking for TIMEOUT_CYCLES cycles.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | lines released, tx_ready high, waiting for tx_valid
// INHIBIT   | clock held low; start bit (data low) asserted on last cycle
// RELEASE   | clock released, start bit held; bit count cleared
// SHIFT     | each device clock fall drives d0..d7, parity, then stop
// ACK       | next fall samples the device ACK on the data line
// WAIT_IDLE | wait for clock and data both high, then report done

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000
`ifdef PS2_TX_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1000000
`endif
) (
  input  logic       FPGAClk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, RELEASE, SHIFT, ACK, WAIT_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d, bit_cnt_inc;
  logic [7:0]       byte_q, byte_d;
  logic             parity_q, parity_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             err_flag_q, err_flag_d;
  logic             clk_s1, clk_s2, clk_prev;
  logic             data_s1, data_s2;
  logic             fall;

  // Two-flop synchronisers on both pins plus a delayed copy of the clock for edge detection
  always_ff @(posedge FPGAClk or posedge rst) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data_in;
      data_s2  <= data_s1;
    end
  end

  assign fall        = clk_prev & ~clk_s2;
  assign bit_cnt_inc = (bit_cnt_q == 4'd11) ? 4'd11 : bit_cnt_q + 4'd1;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_q;
  logic            waiting;
  logic            wd_expired;

  assign waiting    = (state_q == SHIFT) || (state_q == ACK) || (state_q == WAIT_IDLE);
  assign wd_expired = waiting && !fall && (wd_cnt_q == '0);

  // Watchdog: reload on entry to RELEASE and on every fall, count down while waiting on the device
  always_ff @(posedge FPGAClk or posedge rst) begin
    if (rst) begin
      wd_cnt_q <= WD_W'(TIMEOUT_CYCLES - 1);
    end else if (((state_q == INHIBIT) && (inh_cnt_q == '0)) || fall) begin
      wd_cnt_q <= WD_W'(TIMEOUT_CYCLES - 1);
    end else if (waiting && (wd_cnt_q != '0)) begin
      wd_cnt_q <= wd_cnt_q - WD_W'(1);
    end
  end
`endif

  // State, counters and registered line enables / status pulses
  always_ff @(posedge FPGAClk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      inh_cnt_q  <= '0;
      bit_cnt_q  <= 4'd0;
      byte_q     <= 8'd0;
      parity_q   <= 1'b0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inh_cnt_q  <= inh_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_q     <= byte_d;
      parity_q   <= parity_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_flag_q <= err_flag_d;
    end
  end

  // Next-state logic; line enables are computed one cycle ahead so the pins come straight off flops
  always_comb begin
    state_d    = state_q;
    inh_cnt_d  = inh_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    byte_d     = byte_q;
    parity_d   = parity_q;
    clk_oe_d   = clk_oe_q;
    data_oe_d  = data_oe_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_flag_d = err_flag_q;
    case (state_q)
      IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid) begin
          byte_d     = tx_data;
          parity_d   = ~^tx_data;
          inh_cnt_d  = INH_W'(INHIBIT_CYCLES - 1);
          err_flag_d = 1'b0;
          clk_oe_d   = 1'b1;
          data_oe_d  = (INHIBIT_CYCLES == 1);
          state_d    = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_cnt_q == '0) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          bit_cnt_d = 4'd0;
          state_d   = RELEASE;
        end else begin
          inh_cnt_d = inh_cnt_q - INH_W'(1);
          data_oe_d = (inh_cnt_q == INH_W'(1));
        end
      end
      RELEASE: begin
        bit_cnt_d = 4'd0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        if (fall) begin
          bit_cnt_d = bit_cnt_inc;
          if (bit_cnt_q < 4'd8) begin
            data_oe_d = ~byte_q[bit_cnt_q[2:0]];
          end else if (bit_cnt_q == 4'd8) begin
            data_oe_d = ~parity_q;
          end else begin
            data_oe_d = 1'b0;
            state_d   = ACK;
          end
        end
      end
      ACK: begin
        if (fall) begin
          bit_cnt_d = bit_cnt_inc;
          state_d   = WAIT_IDLE;
          if (data_s2) begin
            err_d      = 1'b1;
            err_flag_d = 1'b1;
          end
        end
      end
      WAIT_IDLE: begin
        if (clk_s2 && data_s2) begin
          done_d  = ~err_flag_q;
          state_d = IDLE;
        end
      end
      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
`ifdef PS2_TX_TIMEOUT_EN
    // A byte that already reported a missing ACK does not report again on timeout
    if (wd_expired && (state_d != IDLE)) begin
      clk_oe_d   = 1'b0;
      data_oe_d  = 1'b0;
      done_d     = 1'b0;
      err_d      = ~err_flag_q;
      err_flag_d = 1'b1;
      state_d    = IDLE;
    end
`endif
  end

  assign tx_ready    = (state_q == IDLE);
  assign tx_busy     = (state_q != IDLE);
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_done     = done_q;
  assign tx_err      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a table of bytes is sent through a device model that
// clocks the frame and optionally ACKs, with the line bits captured before each
// fall; hand-written sequences cover reset mid-frame, idle clock traffic and,
// when PS2_TX_TIMEOUT_EN is defined, the watchdog.

module tb_ps2_host_tx;

  localparam int INH        = 5000;
  localparam int HALF       = 20;
  localparam int TB_TIMEOUT = 2000;

  logic       FPGAClk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_err;

  logic dev_clk;
  logic dev_data;

  // open-drain wires: either side may pull low
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH)
`ifdef PS2_TX_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TB_TIMEOUT)
`endif
  ) dut (
    .FPGAClk    (FPGAClk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_err     (tx_err)
  );

  initial FPGAClk = 1'b0;
  always #5 FPGAClk = ~FPGAClk;

  int tests = 0;
  int fails = 0;

  int done_seen = 0;
  int err_seen  = 0;
  int both_seen = 0;
  int inh_run   = 0;
  int last_inh  = 0;

  logic [10:0] cap;

  // pulse counters and inhibit run length, sampled on the falling clock edge
  always @(negedge FPGAClk) begin
    if (tx_done) done_seen++;
    if (tx_err) err_seen++;
    if (tx_done && tx_err) both_seen++;
    if (ps2_clk_oe) inh_run++;
    else if (inh_run != 0) begin
      last_inh = inh_run;
      inh_run  = 0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge FPGAClk);
    #1;
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!tx_busy && n < 20) begin tick(); n++; end
    check("start_busy", 32'(tx_busy), 32'd1);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!tx_ready && n < 400) begin tick(); n++; end
    check("ready_back", 32'(tx_ready), 32'd1);
  endtask

  // device side: wait for the host to pull clock low and then release it with data low
  task automatic wait_request();
    int n = 0;
    while (!ps2_clk_oe && n < 200) begin tick(); n++; end
    n = 0;
    while (ps2_clk_oe && n < INH + 100) begin tick(); n++; end
    check("request_to_send", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'b01);
    repeat (10) tick();
  endtask

  // device clocks falls first_k..last_k, capturing the data line before each fall
  task automatic dev_falls(input int first_k, input int last_k, input bit ack);
    for (int k = first_k; k <= last_k; k++) begin
      repeat (HALF) tick();
      if (k == 11) begin
        cap[10] = ps2_data_in;
        if (ack) dev_data = 1'b0;
        repeat (3) tick();
      end else begin
        cap[k-1] = ps2_data_in;
      end
      dev_clk = 1'b0;
      repeat (HALF) tick();
      dev_clk = 1'b1;
      if (k == 11) begin
        repeat (5) tick();
        dev_data = 1'b1;
      end
    end
  endtask

  typedef struct {
    logic [7:0] data;
    bit         ack;
    bit         chain;
    logic [9:0] exp_line;
    int         exp_done;
    int         exp_err;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int d0, e0, n, viol;
    cap = '0;

    // line = {parity, d7..d0, start}
    vecs[0] = '{data: 8'hED, ack: 1'b1, chain: 1'b0, exp_line: 10'h3DA, exp_done: 1, exp_err: 0};
    vecs[1] = '{data: 8'h01, ack: 1'b0, chain: 1'b0, exp_line: 10'h002, exp_done: 0, exp_err: 1};
    vecs[2] = '{data: 8'h00, ack: 1'b1, chain: 1'b1, exp_line: 10'h200, exp_done: 1, exp_err: 0};
    vecs[3] = '{data: 8'hFF, ack: 1'b1, chain: 1'b0, exp_line: 10'h3FE, exp_done: 1, exp_err: 0};
    vecs[4] = '{data: 8'hA5, ack: 1'b0, chain: 1'b0, exp_line: 10'h34A, exp_done: 0, exp_err: 1};

    rst      = 1'b1;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (5) tick();
    check("reset_outputs",
          {26'd0, tx_ready, tx_busy, ps2_clk_oe, ps2_data_oe, tx_done, tx_err}, 32'b100000);
    rst = 1'b0;
    repeat (3) tick();
    check("idle_outputs",
          {26'd0, tx_ready, tx_busy, ps2_clk_oe, ps2_data_oe, tx_done, tx_err}, 32'b100000);

    for (int r = 0; r < 5; r++) begin
      if (!(r > 0 && vecs[r-1].chain)) begin
        tx_data  = vecs[r].data;
        tx_valid = 1'b1;
      end
      d0 = done_seen;
      e0 = err_seen;
      wait_busy();
      if (vecs[r].chain && r < 4) tx_data = vecs[r+1].data;
      else tx_valid = 1'b0;
      wait_request();
      dev_falls(1, 11, vecs[r].ack);
      wait_ready();
      check($sformatf("line_bits[%0d]", r), 32'(cap[9:0]), 32'(vecs[r].exp_line));
      check($sformatf("stop_bit[%0d]", r), 32'(cap[10]), 32'd1);
      check($sformatf("inhibit_len[%0d]", r), 32'(last_inh), 32'(INH));
      check($sformatf("done_count[%0d]", r), 32'(done_seen - d0), 32'(vecs[r].exp_done));
      check($sformatf("err_count[%0d]", r), 32'(err_seen - e0), 32'(vecs[r].exp_err));
    end
    repeat (3) tick();

    // reset after fall 5: both enables drop before the next clock edge, nothing reported
    tx_data  = 8'hED;
    tx_valid = 1'b1;
    wait_busy();
    tx_valid = 1'b0;
    wait_request();
    dev_falls(1, 5, 1'b0);
    check("pre_reset_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'b01);
    d0 = done_seen;
    e0 = err_seen;
    #2;
    rst = 1'b1;
    #1;
    check("reset_release_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'b00);
    tick();
    rst = 1'b0;
    tick();
    check("ready_after_reset", 32'(tx_ready), 32'd1);
    dev_falls(6, 11, 1'b0);
    repeat (10) tick();
    check("no_pulse_after_reset", 32'((done_seen - d0) + (err_seen - e0)), 32'd0);
    check("idle_after_reset", {29'd0, tx_ready, ps2_clk_oe, ps2_data_oe}, 32'b100);

    // clock traffic in IDLE must not move the block
    d0   = done_seen;
    e0   = err_seen;
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      dev_clk = ~dev_clk;
      repeat (4) begin
        tick();
        if (ps2_clk_oe || ps2_data_oe || !tx_ready || tx_busy) viol++;
      end
    end
    dev_clk = 1'b1;
    check("idle_clock_toggle", 32'(viol), 32'd0);
    check("idle_toggle_pulses", 32'((done_seen - d0) + (err_seen - e0)), 32'd0);

`ifdef PS2_TX_TIMEOUT_EN
    // device stops after fall 4: error about TB_TIMEOUT cycles after that fall
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    wait_busy();
    tx_valid = 1'b0;
    wait_request();
    d0 = done_seen;
    e0 = err_seen;
    dev_falls(1, 4, 1'b0);
    n = 0;
    while (err_seen == e0 && n < TB_TIMEOUT + 200) begin tick(); n++; end
    check("timeout_window", 32'(n >= TB_TIMEOUT - HALF && n <= TB_TIMEOUT - HALF + 6), 32'd1);
    tick();
    check("timeout_released", {29'd0, tx_ready, ps2_clk_oe, ps2_data_oe}, 32'b100);
    check("timeout_pulses", 32'((done_seen - d0) * 16 + (err_seen - e0)), 32'd1);
`endif

    check("done_err_exclusive", 32'(both_seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
